// File: rtl/ip_tx_arb.sv
// Per-frame arbiter sharing the IP stack transmit port between S_COUNT sources.
// Headers are captured into registers; payload is a zero-latency mux of the granted source.
//
// state   | meaning
// IDLE    | pick a winner, accept its header and capture the fields
// HDR     | present the registered header to the stack
// PAYLOAD | pass the granted source's payload through until tlast
module ip_tx_arb #(
    parameter int S_COUNT         = 2,
    parameter int ARB_ROUND_ROBIN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [S_COUNT-1:0]    s_ip_hdr_valid,
    output logic [S_COUNT-1:0]    s_ip_hdr_ready,
    input  logic [6*S_COUNT-1:0]  s_ip_dscp,
    input  logic [2*S_COUNT-1:0]  s_ip_ecn,
    input  logic [16*S_COUNT-1:0] s_ip_length,
    input  logic [8*S_COUNT-1:0]  s_ip_ttl,
    input  logic [8*S_COUNT-1:0]  s_ip_protocol,
    input  logic [32*S_COUNT-1:0] s_ip_source_ip,
    input  logic [32*S_COUNT-1:0] s_ip_dest_ip,
    input  logic [8*S_COUNT-1:0]  s_ip_payload_axis_tdata,
    input  logic [S_COUNT-1:0]    s_ip_payload_axis_tvalid,
    output logic [S_COUNT-1:0]    s_ip_payload_axis_tready,
    input  logic [S_COUNT-1:0]    s_ip_payload_axis_tlast,
    input  logic [S_COUNT-1:0]    s_ip_payload_axis_tuser,
    output logic                  m_ip_hdr_valid,
    input  logic                  m_ip_hdr_ready,
    output logic [5:0]            m_ip_dscp,
    output logic [1:0]            m_ip_ecn,
    output logic [15:0]           m_ip_length,
    output logic [7:0]            m_ip_ttl,
    output logic [7:0]            m_ip_protocol,
    output logic [31:0]           m_ip_source_ip,
    output logic [31:0]           m_ip_dest_ip,
    output logic [7:0]            m_ip_payload_axis_tdata,
    output logic                  m_ip_payload_axis_tvalid,
    input  logic                  m_ip_payload_axis_tready,
    output logic                  m_ip_payload_axis_tlast,
    output logic                  m_ip_payload_axis_tuser,
    output logic [2:0]            grant_index,
    output logic                  busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD} state_t;

    state_t      state_q, state_d;
    logic        hdr_valid_q, hdr_valid_d;
    logic [5:0]  dscp_q, dscp_d;
    logic [1:0]  ecn_q, ecn_d;
    logic [15:0] length_q, length_d;
    logic [7:0]  ttl_q, ttl_d;
    logic [7:0]  protocol_q, protocol_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic [31:0] dst_ip_q, dst_ip_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_grant_q, last_grant_d;

    logic [2:0]  winner, win_hi, win_lo;
    logic        found_hi, found_lo;

    // win_hi: lowest requester above last_grant; win_lo: lowest requester overall (wrap case)
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = S_COUNT-1; i >= 0; i--) begin
            if (s_ip_hdr_valid[i]) begin
                win_lo   = 3'(i);
                found_lo = 1'b1;
                if (3'(i) > last_grant_q) begin
                    win_hi   = 3'(i);
                    found_hi = 1'b1;
                end
            end
        end
        if (ARB_ROUND_ROBIN != 0 && found_hi) winner = win_hi;
        else                                  winner = win_lo;
    end

    always_comb begin
        state_d                  = state_q;
        hdr_valid_d              = hdr_valid_q;
        dscp_d                   = dscp_q;
        ecn_d                    = ecn_q;
        length_d                 = length_q;
        ttl_d                    = ttl_q;
        protocol_d               = protocol_q;
        src_ip_d                 = src_ip_q;
        dst_ip_d                 = dst_ip_q;
        grant_d                  = grant_q;
        last_grant_d             = last_grant_q;
        s_ip_hdr_ready           = '0;
        s_ip_payload_axis_tready = '0;
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // rst_n gate keeps every ready low while reset is held
                if (found_lo && rst_n) begin
                    s_ip_hdr_ready = S_COUNT'(1) << winner;
                    for (int i = 0; i < S_COUNT; i++) begin
                        if (3'(i) == winner) begin
                            dscp_d     = s_ip_dscp[i*6 +: 6];
                            ecn_d      = s_ip_ecn[i*2 +: 2];
                            length_d   = s_ip_length[i*16 +: 16];
                            ttl_d      = s_ip_ttl[i*8 +: 8];
                            protocol_d = s_ip_protocol[i*8 +: 8];
                            src_ip_d   = s_ip_source_ip[i*32 +: 32];
                            dst_ip_d   = s_ip_dest_ip[i*32 +: 32];
                        end
                    end
                    grant_d      = winner;
                    last_grant_d = winner;
                    hdr_valid_d  = 1'b1;
                    state_d      = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_ip_hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                for (int i = 0; i < S_COUNT; i++) begin
                    if (3'(i) == grant_q) begin
                        m_ip_payload_axis_tdata  = s_ip_payload_axis_tdata[i*8 +: 8];
                        m_ip_payload_axis_tvalid = s_ip_payload_axis_tvalid[i];
                        m_ip_payload_axis_tlast  = s_ip_payload_axis_tlast[i];
                        m_ip_payload_axis_tuser  = s_ip_payload_axis_tuser[i];
                    end
                end
                s_ip_payload_axis_tready = m_ip_payload_axis_tready ? (S_COUNT'(1) << grant_q) : '0;
                if (m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && m_ip_payload_axis_tlast)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_valid_q  <= 1'b0;
            dscp_q       <= '0;
            ecn_q        <= '0;
            length_q     <= '0;
            ttl_q        <= '0;
            protocol_q   <= '0;
            src_ip_q     <= '0;
            dst_ip_q     <= '0;
            grant_q      <= '0;
            last_grant_q <= 3'(S_COUNT-1);
        end else begin
            state_q      <= state_d;
            hdr_valid_q  <= hdr_valid_d;
            dscp_q       <= dscp_d;
            ecn_q        <= ecn_d;
            length_q     <= length_d;
            ttl_q        <= ttl_d;
            protocol_q   <= protocol_d;
            src_ip_q     <= src_ip_d;
            dst_ip_q     <= dst_ip_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign m_ip_hdr_valid = hdr_valid_q;
    assign m_ip_dscp      = dscp_q;
    assign m_ip_ecn       = ecn_q;
    assign m_ip_length    = length_q;
    assign m_ip_ttl       = ttl_q;
    assign m_ip_protocol  = protocol_q;
    assign m_ip_source_ip = src_ip_q;
    assign m_ip_dest_ip   = dst_ip_q;
    assign grant_index    = grant_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_ip_tx_arb.sv
// Directed bench for ip_tx_arb: a round-robin and a fixed-priority instance share
// the source stimulus; a scoreboard of headers, grants and beats checks the selected one.
module tb_ip_tx_arb;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic use_fp = 1'b0;
    always #5 clk = ~clk;

    logic [S-1:0]    s_hdr_valid, s_tvalid, s_tlast, s_tuser;
    logic [6*S-1:0]  s_dscp;
    logic [2*S-1:0]  s_ecn;
    logic [16*S-1:0] s_length;
    logic [8*S-1:0]  s_ttl, s_proto, s_tdata;
    logic [32*S-1:0] s_sip, s_dip;
    logic            m_hdr_ready, m_tready;

    wire [S-1:0]   rr_hdr_ready, fp_hdr_ready, rr_tready, fp_tready;
    wire           rr_hdr_valid, fp_hdr_valid, rr_tvalid, fp_tvalid;
    wire           rr_tlast, fp_tlast, rr_tuser, fp_tuser, rr_busy, fp_busy;
    wire [103:0]   rr_hdr, fp_hdr;
    wire [7:0]     rr_tdata, fp_tdata;
    wire [2:0]     rr_grant, fp_grant;

    ip_tx_arb #(.S_COUNT(S), .ARB_ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(rr_hdr_ready),
        .s_ip_dscp(s_dscp), .s_ip_ecn(s_ecn), .s_ip_length(s_length), .s_ip_ttl(s_ttl),
        .s_ip_protocol(s_proto), .s_ip_source_ip(s_sip), .s_ip_dest_ip(s_dip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(rr_tready), .s_ip_payload_axis_tlast(s_tlast),
        .s_ip_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(rr_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
        .m_ip_dscp(rr_hdr[103:98]), .m_ip_ecn(rr_hdr[97:96]), .m_ip_length(rr_hdr[95:80]),
        .m_ip_ttl(rr_hdr[79:72]), .m_ip_protocol(rr_hdr[71:64]),
        .m_ip_source_ip(rr_hdr[63:32]), .m_ip_dest_ip(rr_hdr[31:0]),
        .m_ip_payload_axis_tdata(rr_tdata), .m_ip_payload_axis_tvalid(rr_tvalid),
        .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(rr_tlast),
        .m_ip_payload_axis_tuser(rr_tuser), .grant_index(rr_grant), .busy(rr_busy)
    );

    ip_tx_arb #(.S_COUNT(S), .ARB_ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(s_hdr_valid), .s_ip_hdr_ready(fp_hdr_ready),
        .s_ip_dscp(s_dscp), .s_ip_ecn(s_ecn), .s_ip_length(s_length), .s_ip_ttl(s_ttl),
        .s_ip_protocol(s_proto), .s_ip_source_ip(s_sip), .s_ip_dest_ip(s_dip),
        .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid),
        .s_ip_payload_axis_tready(fp_tready), .s_ip_payload_axis_tlast(s_tlast),
        .s_ip_payload_axis_tuser(s_tuser),
        .m_ip_hdr_valid(fp_hdr_valid), .m_ip_hdr_ready(m_hdr_ready),
        .m_ip_dscp(fp_hdr[103:98]), .m_ip_ecn(fp_hdr[97:96]), .m_ip_length(fp_hdr[95:80]),
        .m_ip_ttl(fp_hdr[79:72]), .m_ip_protocol(fp_hdr[71:64]),
        .m_ip_source_ip(fp_hdr[63:32]), .m_ip_dest_ip(fp_hdr[31:0]),
        .m_ip_payload_axis_tdata(fp_tdata), .m_ip_payload_axis_tvalid(fp_tvalid),
        .m_ip_payload_axis_tready(m_tready), .m_ip_payload_axis_tlast(fp_tlast),
        .m_ip_payload_axis_tuser(fp_tuser), .grant_index(fp_grant), .busy(fp_busy)
    );

    wire [S-1:0] o_hdr_ready = use_fp ? fp_hdr_ready : rr_hdr_ready;
    wire [S-1:0] o_tready    = use_fp ? fp_tready    : rr_tready;
    wire         o_hdr_valid = use_fp ? fp_hdr_valid : rr_hdr_valid;
    wire [103:0] o_hdr       = use_fp ? fp_hdr       : rr_hdr;
    wire [7:0]   o_tdata     = use_fp ? fp_tdata     : rr_tdata;
    wire         o_tvalid    = use_fp ? fp_tvalid    : rr_tvalid;
    wire         o_tlast     = use_fp ? fp_tlast     : rr_tlast;
    wire         o_tuser     = use_fp ? fp_tuser     : rr_tuser;
    wire [2:0]   o_grant     = use_fp ? fp_grant     : rr_grant;
    wire         o_busy      = use_fp ? fp_busy      : rr_busy;

    // source-side stimulus queues and expected-output scoreboard
    logic [103:0] hq[S][$];
    logic [9:0]   pq[S][$];
    logic [103:0] exp_hdr[$];
    logic [2:0]   exp_grant[$];
    logic [9:0]   exp_beat[$];

    int       n_checks = 0;
    int       n_err = 0;
    int       phase = 0;
    int       n_beats = 0;
    int       hdr_hold = 0;
    bit       tog = 1'b0;
    bit       prev_hdr_acc = 1'b0;
    bit       prev_last = 1'b0;
    bit       saw_hv = 1'b0;
    logic [2:0]   cur_grant = '0;
    logic [S-1:0] hs_hdr = '0;
    logic [S-1:0] hs_pay = '0;

    task automatic chk(input string tag, input logic [103:0] obs, input logic [103:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [103:0] h;
        logic [9:0]   b;
        for (int i = 0; i < S; i++) begin
            h = (hq[i].size() != 0) ? hq[i][0] : '0;
            b = (pq[i].size() != 0) ? pq[i][0] : '0;
            s_hdr_valid[i]     = (hq[i].size() != 0);
            s_dscp[i*6 +: 6]   = h[103:98];
            s_ecn[i*2 +: 2]    = h[97:96];
            s_length[i*16 +: 16] = h[95:80];
            s_ttl[i*8 +: 8]    = h[79:72];
            s_proto[i*8 +: 8]  = h[71:64];
            s_sip[i*32 +: 32]  = h[63:32];
            s_dip[i*32 +: 32]  = h[31:0];
            s_tvalid[i]        = (pq[i].size() != 0);
            s_tdata[i*8 +: 8]  = b[7:0];
            s_tuser[i]         = b[8];
            s_tlast[i]         = b[9];
        end
        m_hdr_ready = (hdr_hold == 0);
    endtask

    task automatic flush();
        for (int i = 0; i < S; i++) begin
            hq[i].delete();
            pq[i].delete();
        end
        exp_hdr.delete();
        exp_grant.delete();
        exp_beat.delete();
        phase = 0;
        prev_hdr_acc = 1'b0;
        prev_last = 1'b0;
        saw_hv = 1'b0;
        hdr_hold = 0;
        tog = 1'b0;
        m_tready = 1'b1;
        hs_hdr = '0;
        hs_pay = '0;
    endtask

    task automatic send(input int src, input logic [31:0] dip, input logic [15:0] len,
                        input int nb, input logic [7:0] base, input bit user_last);
        logic [103:0] h;
        logic [9:0]   b;
        h = {6'(src + 9), 2'(src + 1), len, 8'(64 + src), (src == 0) ? 8'd17 : 8'd1,
             32'h0A00_0001 + 32'(src), dip};
        hq[src].push_back(h);
        exp_hdr.push_back(h);
        exp_grant.push_back(3'(src));
        for (int k = 0; k < nb; k++) begin
            b = {(k == nb - 1), (user_last && (k == nb - 1)), 8'(int'(base) + k)};
            pq[src].push_back(b);
            exp_beat.push_back(b);
        end
    endtask

    // called on the falling edge: handshakes seen here complete on the next rising edge
    task automatic sample();
        logic [9:0] eb;
        hs_hdr = s_hdr_valid & o_hdr_ready;
        hs_pay = s_tvalid & o_tready;
        saw_hv = o_hdr_valid;
        if (prev_hdr_acc) chk("hdr_valid_rise", 104'(o_hdr_valid), 104'(1));
        if (prev_last)    chk("busy_fall", 104'(o_busy), 104'(0));
        prev_hdr_acc = (hs_hdr != '0);
        prev_last = 1'b0;
        if (phase == 1) begin
            chk("s_tready_mirror", 104'(o_tready), 104'(m_tready ? (S'(1) << cur_grant) : S'(0)));
            chk("hdr_ready_in_payload", 104'(o_hdr_ready), 104'(0));
            if (o_tvalid && m_tready) begin
                n_beats++;
                eb = (exp_beat.size() != 0) ? exp_beat.pop_front() : 10'h3FF;
                chk("beat", 104'({o_tlast, o_tuser, o_tdata}), 104'(eb));
                if (eb[9]) begin
                    phase = 0;
                    prev_last = 1'b1;
                end
            end
        end else begin
            chk("tvalid_outside_payload", 104'(o_tvalid), 104'(0));
            chk("s_tready_outside_payload", 104'(o_tready), 104'(0));
            if (o_hdr_valid)
                chk("hdr_ready_in_hdr", 104'(o_hdr_ready), 104'(0));
            else
                chk("hdr_ready_idle", 104'(o_hdr_ready),
                    104'((s_hdr_valid != '0 && exp_grant.size() != 0) ? (S'(1) << exp_grant[0]) : S'(0)));
        end
        if (o_hdr_valid) begin
            chk("hdr_fields", o_hdr, (exp_hdr.size() != 0) ? exp_hdr[0] : {104{1'b1}});
            chk("grant_index", 104'(o_grant), 104'((exp_grant.size() != 0) ? exp_grant[0] : 3'h7));
            if (m_hdr_ready) begin
                if (exp_hdr.size() != 0) void'(exp_hdr.pop_front());
                cur_grant = (exp_grant.size() != 0) ? exp_grant.pop_front() : 3'h7;
                phase = 1;
            end
        end
    endtask

    task automatic update();
        for (int i = 0; i < S; i++) begin
            if (hs_hdr[i] && hq[i].size() != 0) void'(hq[i].pop_front());
            if (hs_pay[i] && pq[i].size() != 0) void'(pq[i].pop_front());
        end
        if (saw_hv && hdr_hold > 0) hdr_hold--;
        m_tready = tog ? ~m_tready : 1'b1;
        drive();
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic run(input string tag, input int budget);
        int c;
        int left;
        c = 0;
        drive();
        while ((exp_beat.size() != 0 || exp_hdr.size() != 0) && c < budget) begin
            tick();
            c++;
        end
        tick();
        tick();
        left = exp_beat.size() + exp_hdr.size();
        for (int i = 0; i < S; i++) left += hq[i].size() + pq[i].size();
        chk({tag, "_all_transferred"}, 104'(left), 104'(0));
        tog = 1'b0;
        m_tready = 1'b1;
        drive();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_hdr_fields", o_hdr, 104'(0));
        chk("rst_ctrl", 104'({o_hdr_valid, o_tvalid, o_tdata, o_tlast, o_tuser, o_grant,
                              o_busy, o_hdr_ready, o_tready}), 104'(0));
        flush();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        flush();
        drive();
        do_reset();

        // contention under round-robin: grants must alternate 0,1,0,1
        send(0, 32'hC0A8_0001, 16'd24, 4, 8'h10, 1'b0);
        send(1, 32'hC0A8_0002, 16'd24, 4, 8'h20, 1'b0);
        send(0, 32'hC0A8_0003, 16'd24, 4, 8'h30, 1'b0);
        send(1, 32'hC0A8_0004, 16'd24, 4, 8'h40, 1'b0);
        run("contention", 200);

        // single source, 8 bytes 0x00..0x07
        send(0, 32'hC0A8_0102, 16'd28, 8, 8'h00, 1'b0);
        run("single", 200);

        // backpressure: header stalled 5 cycles, payload ready toggling
        hdr_hold = 5;
        tog = 1'b1;
        send(1, 32'h0A0B_0C0D, 16'd26, 6, 8'hA0, 1'b0);
        run("backpressure", 200);

        // tuser on the last beat, followed by a normal frame from the other source
        send(0, 32'hC0A8_0201, 16'd23, 3, 8'h60, 1'b1);
        send(1, 32'hC0A8_0202, 16'd22, 2, 8'h70, 1'b0);
        run("tuser_last", 200);

        // async reset after 3 of 8 bytes; source 0 must still win first afterwards
        send(0, 32'hC0A8_0301, 16'd28, 8, 8'h80, 1'b0);
        drive();
        n_beats = 0;
        c = 0;
        while (n_beats < 3 && c < 100) begin
            tick();
            c++;
        end
        chk("beats_before_reset", 104'(n_beats), 104'(3));
        do_reset();
        send(0, 32'hC0A8_0401, 16'd24, 4, 8'h90, 1'b0);
        send(1, 32'hC0A8_0402, 16'd24, 4, 8'hB0, 1'b0);
        run("after_reset", 200);

        // fixed priority: source 0 keeps winning while it has headers pending
        use_fp = 1'b1;
        do_reset();
        send(0, 32'hC0A8_0501, 16'd24, 4, 8'hC0, 1'b0);
        send(0, 32'hC0A8_0502, 16'd24, 4, 8'hC8, 1'b0);
        send(0, 32'hC0A8_0503, 16'd24, 4, 8'hD0, 1'b0);
        send(1, 32'hC0A8_0504, 16'd24, 4, 8'hE0, 1'b0);
        run("fixed_priority", 300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ip_tx_arb.md
Name: ip_tx_arb

Overview:
- Shares the single IP transmit input of the IPv4/ARP stack between S_COUNT independent IP frame sources, for example UDP, ICMP and a raw-IP client.
- Arbitrates per frame. A granted source holds the grant from header acceptance until its payload tlast beat.
- Headers are registered. Payload passes through a zero-latency mux.
- Sits directly in front of the stack's s_ip_* port.

Parameters:
- S_COUNT, 2: number of requesting sources (2..8).
- ARB_ROUND_ROBIN, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_ip_hdr_valid  in  S_COUNT  per-source header valid
- s_ip_hdr_ready  out  S_COUNT  per-source header accept
- s_ip_dscp  in  6*S_COUNT  per-source DSCP, source i at bits [6i+5:6i]
- s_ip_ecn  in  2*S_COUNT  per-source ECN
- s_ip_length  in  16*S_COUNT  per-source IP total length
- s_ip_ttl  in  8*S_COUNT  per-source TTL
- s_ip_protocol  in  8*S_COUNT  per-source protocol
- s_ip_source_ip  in  32*S_COUNT  per-source source IP
- s_ip_dest_ip  in  32*S_COUNT  per-source destination IP
- s_ip_payload_axis_tdata  in  8*S_COUNT  per-source payload data
- s_ip_payload_axis_tvalid  in  S_COUNT  per-source payload valid
- s_ip_payload_axis_tready  out  S_COUNT  per-source payload ready
- s_ip_payload_axis_tlast  in  S_COUNT  per-source payload last
- s_ip_payload_axis_tuser  in  S_COUNT  per-source payload user/error
- m_ip_hdr_valid  out  1  header valid to IP stack
- m_ip_hdr_ready  in  1  header ready from IP stack
- m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol, m_ip_source_ip, m_ip_dest_ip  out  6/2/16/8/8/32/32  registered header fields
- m_ip_payload_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  payload to IP stack
- grant_index  out  3  index of the current or last granted source
- busy  out  1  high in HDR or PAYLOAD state

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - m_ip_hdr_valid = 0; all header field registers = 0.
  - grant_index = 0.
  - last_grant = S_COUNT-1, so source 0 wins first under round-robin.
  - busy = 0; all s_*_ready = 0; m payload tvalid = 0.
- Reset asserted mid-frame abandons the frame. Nothing is resumed after release.
- IDLE:
  - The winner is computed combinationally from s_ip_hdr_valid.
  - Round-robin: first valid index searching upward from last_grant+1, wrapping S_COUNT-1 -> 0.
  - Fixed priority: lowest valid index.
  - If any source is valid:
    - s_ip_hdr_ready[winner] = 1 in this cycle; all other hdr_ready = 0.
    - The winner's header fields are captured into the output registers.
    - grant_index <= winner; last_grant <= winner; go to HDR.
  - hdr_ready depends on hdr_valid only, never the reverse.
- HDR:
  - m_ip_hdr_valid = 1 with the fields held stable.
  - On m_ip_hdr_ready = 1: m_ip_hdr_valid <= 0, go to PAYLOAD.
  - No s_ip_hdr_ready is asserted in HDR.
- PAYLOAD:
  - m tdata/tvalid/tlast/tuser = source[grant_index].
  - s tready[grant_index] = m tready; every other s tready = 0.
  - On m tvalid & m tready & m tlast: go to IDLE.
  - New headers from any source wait. Minimum of one IDLE cycle between frames.
- Outside PAYLOAD:
  - m tvalid = 0; all s tready = 0.
  - Payload beats presented early are stalled, not dropped.
- A payload beat with tuser = 1 is forwarded unchanged. The arbiter does not inspect it.
- Zero-length frames are not supported; every frame carries at least one beat with tlast.
- Throughput: header path adds 1 cycle. Payload is 0-cycle combinational, one beat per cycle when tready is high.
- Arbitration fairness: under round-robin with all sources continuously requesting, grants rotate 0,1,...,S_COUNT-1,0.

Test Plan:
- Single source: S_COUNT=2. Source 0 sends header (dest_ip 0xC0A80102, length 28) plus 8 payload bytes 0x00..0x07 with m readies held high.
  - Required: m_ip_hdr_valid rises 1 cycle after hdr accept, with identical fields.
  - Required: 8 beats out, tlast on 0x07; busy falls the cycle after tlast.
- Contention (round-robin): both sources request continuously with 4-byte frames.
  - Required: grant_index sequence 0,1,0,1.
  - Required: no interleaved beats; source 1 hdr_ready stays 0 while source 0 is in PAYLOAD.
- Fixed priority (ARB_ROUND_ROBIN=0): both request continuously.
  - Required: source 0 is granted every frame; source 1 is starved while source 0 stays valid.
- Backpressure: m_ip_hdr_ready held 0 for 5 cycles, then m tready toggled 1-0 per cycle.
  - Required: header fields stable across all 5 cycles.
  - Required: each byte transferred exactly once; s tready of the granted source mirrors m tready.
- Async reset mid-payload, after 3 of 8 bytes:
  - Required: all outputs 0 immediately.
  - Required: after release, source 0 wins first, and a new frame passes cleanly.
- tuser=1 on the last beat: required to be forwarded with tlast=1, tuser=1, and arbitration continues normally.
